// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART transmitter: show-ahead valid/ready in and out.
// Define UART_TX_FIFO_OVERFLOW_EN to add a sticky overflow flag for rejected enqueues.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           enq_data,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   output logic [WIDTH-1:0]           deq_data,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [$clog2(DEPTH):0]     count
`ifdef UART_TX_FIFO_OVERFLOW_EN
   ,
   output logic                       overflow
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             enq_fire;
   logic             deq_fire;

   assign enq_fire = enq_valid && enq_ready;
   assign deq_fire = deq_valid && deq_ready;

   // Show-ahead head byte straight from the registered read pointer
   assign deq_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({enq_fire, deq_fire})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // Flags are registered from next count so they never see enq_valid/deq_ready combinationally
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         enq_ready <= 1'b1;
         deq_valid <= 1'b0;
      end else begin
         if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_nxt;
         enq_ready <= (count_nxt != CNT_W'(DEPTH));
         deq_valid <= (count_nxt != CNT_W'(0));
      end
   end

   // Storage is not reset; contents behind rd_ptr/wr_ptr are don't-care
   always_ff @(posedge clk) begin
      if (!reset && enq_fire) mem[wr_ptr] <= enq_data;
   end

`ifdef UART_TX_FIFO_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (reset)                       overflow <= 1'b0;
      else if (enq_valid && !enq_ready) overflow <= 1'b1;
   end
`endif

endmodule
